// File: rtl/pwm_duty_sequencer.sv
// pwm_duty_sequencer: owns the PWM duty register, arbitrating host commands and buttons
// and ramping duty_out toward the target only on PWM period boundaries.
module pwm_duty_sequencer #(
    parameter int DUTY_W    = 4,
    parameter int DUTY_MAX  = 10,
    parameter int DUTY_INIT = 5,
    parameter int RAMP_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              period_start,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic [RAMP_W-1:0] cmd_ramp,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              at_target,
    output logic              clip
);
    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state, state_n;
    logic [DUTY_W-1:0] target, target_n, duty_n, clipped, stepped;
    logic [RAMP_W-1:0] ramp_len, ramp_len_n, ramp_cnt, ramp_cnt_n;
    logic              clip_n, at_target_n, accept;

    assign cmd_ready = (state == IDLE) & ena;
    assign busy      = state == RAMP;
    assign accept    = cmd_valid & cmd_ready;
    assign clipped   = cmd_duty > MAX_V ? MAX_V : cmd_duty;
    assign stepped   = target > duty_out ? duty_out + DUTY_W'(1) : duty_out - DUTY_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            duty_out  <= INIT_V;
            target    <= INIT_V;
            ramp_len  <= '0;
            ramp_cnt  <= '0;
            clip      <= 1'b0;
            at_target <= 1'b1;
        end else begin
            state     <= state_n;
            duty_out  <= duty_n;
            target    <= target_n;
            ramp_len  <= ramp_len_n;
            ramp_cnt  <= ramp_cnt_n;
            clip      <= clip_n;
            at_target <= at_target_n;
        end
    end

    always_comb begin
        state_n    = state;
        duty_n     = duty_out;
        target_n   = target;
        ramp_len_n = ramp_len;
        ramp_cnt_n = ramp_cnt;
        clip_n     = clip;
        if (ena) begin
            clip_n = 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    target_n   = clipped;
                    ramp_len_n = cmd_ramp;
                    ramp_cnt_n = cmd_ramp;
                    clip_n     = cmd_duty > MAX_V;
                    state_n    = clipped == duty_out ? IDLE : RAMP;
                end else if (btn_inc && !btn_dec && duty_out < MAX_V) begin
                    target_n   = duty_out + DUTY_W'(1);
                    ramp_len_n = '0;
                    ramp_cnt_n = '0;
                    state_n    = RAMP;
                end else if (btn_dec && !btn_inc && duty_out != '0) begin
                    target_n   = duty_out - DUTY_W'(1);
                    ramp_len_n = '0;
                    ramp_cnt_n = '0;
                    state_n    = RAMP;
                end
            end else if (period_start) begin
                // ramp_len==0 jumps straight to target; otherwise one step per ramp_len periods
                if (ramp_len == '0) begin
                    duty_n = target;
                end else if (ramp_cnt <= RAMP_W'(1)) begin
                    duty_n     = stepped;
                    ramp_cnt_n = ramp_len;
                end else begin
                    ramp_cnt_n = ramp_cnt - RAMP_W'(1);
                end
                if (duty_n == target) state_n = IDLE;
            end
        end
        at_target_n = duty_n == target_n;
    end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// tb_pwm_duty_sequencer: directed scenario tasks with hand-computed expectations.
module tb_pwm_duty_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       period_start = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_duty = '0;
    logic [7:0] cmd_ramp = '0;
    logic [3:0] duty_out;
    logic       busy;
    logic       at_target;
    logic       clip;
    int checks = 0;
    int failures = 0;

    pwm_duty_sequencer dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .period_start(period_start),
        .btn_inc(btn_inc), .btn_dec(btn_dec), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_duty(cmd_duty), .cmd_ramp(cmd_ramp),
        .duty_out(duty_out), .busy(busy), .at_target(at_target), .clip(clip)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // nine quiet cycles (duty must hold) then one cycle with period_start
    task automatic period();
        logic [3:0] held;
        held = duty_out;
        for (int i = 0; i < 9; i++) begin
            cyc();
            checks++;
            if (duty_out !== held) begin
                failures++;
                $display("FAIL between_boundaries duty_out=%0d required=%0d", duty_out, held);
            end
        end
        period_start = 1'b1;
        cyc();
        period_start = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic send(input logic [3:0] d, input logic [7:0] r);
        cmd_duty = d;
        cmd_ramp = r;
        cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (20) cyc();
        checks++;
        if ({duty_out, cmd_ready, busy, at_target, clip} !== {4'd5, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset duty=%0d ready=%0b busy=%0b at_target=%0b clip=%0b required 5 1 0 1 0",
                     duty_out, cmd_ready, busy, at_target, clip);
        end
    endtask

    task automatic test_ramp();
        send(4'd9, 8'd2);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || at_target !== 1'b0) begin
            failures++;
            $display("FAIL ramp_accept busy=%0b ready=%0b at_target=%0b required 1 0 0", busy, cmd_ready, at_target);
        end
        for (int k = 1; k <= 8; k++) begin
            period();
            checks++;
            if (duty_out !== 4'(5 + k / 2) || busy !== (k < 8)) begin
                failures++;
                $display("FAIL ramp_step%0d duty=%0d busy=%0b required %0d %0b", k, duty_out, busy, 5 + k / 2, k < 8);
            end
        end
        checks++;
        if (cmd_ready !== 1'b1 || at_target !== 1'b1) begin
            failures++;
            $display("FAIL ramp_done ready=%0b at_target=%0b required 1 1", cmd_ready, at_target);
        end
    endtask

    task automatic test_clip();
        send(4'd15, 8'd0);
        checks++;
        if (clip !== 1'b1) begin
            failures++;
            $display("FAIL clip_pulse clip=%0b required 1", clip);
        end
        cyc();
        checks++;
        if (clip !== 1'b0 || duty_out !== 4'd9) begin
            failures++;
            $display("FAIL clip_once clip=%0b duty=%0d required 0 9", clip, duty_out);
        end
        period();
        checks++;
        if (duty_out !== 4'd10 || busy !== 1'b0 || at_target !== 1'b1) begin
            failures++;
            $display("FAIL clip_jump duty=%0d busy=%0b at_target=%0b required 10 0 1", duty_out, busy, at_target);
        end
    endtask

    task automatic test_buttons();
        btn_inc = 1'b1;
        cyc();
        btn_inc = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL inc_at_max busy=%0b required 0", busy);
        end
        period();
        checks++;
        if (duty_out !== 4'd10) begin
            failures++;
            $display("FAIL inc_at_max_duty duty=%0d required 10", duty_out);
        end
        btn_dec = 1'b1;
        cyc();
        btn_dec = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL dec_accept busy=%0b required 1", busy);
        end
        period();
        checks++;
        if (duty_out !== 4'd9 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dec_step duty=%0d busy=%0b required 9 0", duty_out, busy);
        end
        btn_inc = 1'b1;
        btn_dec = 1'b1;
        cyc();
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL both_buttons busy=%0b required 0", busy);
        end
        period();
        checks++;
        if (duty_out !== 4'd9) begin
            failures++;
            $display("FAIL both_buttons_duty duty=%0d required 9", duty_out);
        end
    endtask

    task automatic test_cmd_priority();
        do_reset();
        btn_dec = 1'b1;
        send(4'd2, 8'd1);
        btn_dec = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            btn_inc = 1'b1;
            cyc();
            btn_inc = 1'b0;
            period();
            checks++;
            if (duty_out !== 4'(5 - k) || busy !== (k < 3)) begin
                failures++;
                $display("FAIL priority_step%0d duty=%0d busy=%0b required %0d %0b", k, duty_out, busy, 5 - k, k < 3);
            end
        end
        checks++;
        if (at_target !== 1'b1 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL priority_done at_target=%0b ready=%0b required 1 1", at_target, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        send(4'd9, 8'd1);
        period();
        period();
        checks++;
        if (duty_out !== 4'd7) begin
            failures++;
            $display("FAIL pre_reset duty=%0d required 7", duty_out);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (duty_out !== 4'd5 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_reset duty=%0d busy=%0b required 5 0", duty_out, busy);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_enable();
        send(4'd9, 8'd1);
        period();
        ena = 1'b0;
        period();
        period();
        checks++;
        if (duty_out !== 4'd6 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL ena_freeze duty=%0d busy=%0b ready=%0b required 6 1 0", duty_out, busy, cmd_ready);
        end
        ena = 1'b1;
        period();
        checks++;
        if (duty_out !== 4'd7) begin
            failures++;
            $display("FAIL ena_resume duty=%0d required 7", duty_out);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_clip();
        test_buttons();
        test_cmd_priority();
        test_reset_mid_ramp();
        test_enable();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
